// File: rtl/lcd_pkg.sv
// Shared constants and types for the BCD counter that feeds the LCD driver.
package lcd_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX  = 4'd9;
    localparam bcd_t BCD_ZERO = 4'd0;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_e;

    // Any non-decimal nibble is forced to zero so the digit registers only ever hold 0..9.
    function automatic bcd_t bcd_sanitize(input bcd_t d);
        return (d > BCD_MAX) ? BCD_ZERO : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple chain. Carry/borrow out are combinational so a
// whole 0999 -> 1000 style ripple settles inside a single cycle.
module bcd_digit
    import lcd_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic inc_i,
    input  logic dec_i,
    input  logic carry_in_i,
    input  logic borrow_in_i,
    output logic carry_out_o,
    output logic borrow_out_o,
    output bcd_t digit_o
);

    bcd_t digit_q, digit_d;
    logic step_up, step_dn;

    assign step_up      = inc_i & carry_in_i;
    assign step_dn      = dec_i & borrow_in_i;
    assign carry_out_o  = step_up & (digit_q == BCD_MAX);
    assign borrow_out_o = step_dn & (digit_q == BCD_ZERO);
    assign digit_o      = digit_q;

    // Next digit value: clear beats load beats a count step.
    always_comb begin
        digit_d = digit_q;
        if (clear_i) begin
            digit_d = BCD_ZERO;
        end else if (load_i) begin
            digit_d = bcd_sanitize(load_val_i);
        end else if (step_up) begin
            digit_d = (digit_q == BCD_MAX) ? BCD_ZERO : digit_q + 4'd1;
        end else if (step_dn) begin
            digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) digit_q <= BCD_ZERO;
        else         digit_q <= digit_d;
    end

endmodule

// File: rtl/bcd_count4.sv
// Four-digit BCD up/down counter with prescaled tick and start/stop toggle.
// Define BCD_SATURATE_EN to make the count stop at 9999/0000 instead of wrapping.
module bcd_count4
    import lcd_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        up_dn,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [3:0]  count0,
    output logic [3:0]  count1,
    output logic [3:0]  count2,
    output logic [3:0]  count3,
    output logic        running,
    output logic        wrap
);

    localparam int             PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

    logic          ss_meta_q, ss_sync_q, ss_prev_q;
    logic          ss_edge;
    run_state_e    state_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick, step_ok, inc, dec;
    logic          wrap_q, wrap_d;

    logic [NUM_DIGITS:0] carry, borrow;
    bcd_t                digit_w [NUM_DIGITS];

    assign ss_edge = ss_sync_q & ~ss_prev_q;
    assign tick    = (state_q == RUNNING) && (presc_q == TICK_LAST);
    // A tick that collides with clear or load is dropped entirely.
    assign step_ok = tick & ~clear & ~load;

    // Two-flop synchronizer plus delay stage for rising-edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ss_meta_q <= 1'b0;
            ss_sync_q <= 1'b0;
            ss_prev_q <= 1'b0;
        end else begin
            ss_meta_q <= start_stop;
            ss_sync_q <= ss_meta_q;
            ss_prev_q <= ss_sync_q;
        end
    end

    // Run FSM: every synchronized start_stop edge flips between STOPPED and RUNNING.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STOPPED;
        end else if (ss_edge) begin
            case (state_q)
                STOPPED: state_q <= RUNNING;
                RUNNING: state_q <= STOPPED;
                default: state_q <= STOPPED;
            endcase
        end
    end

    assign running = (state_q == RUNNING);

    // Prescaler next value: zeroed by clear/load, advances only while running.
    always_comb begin
        presc_d = presc_q;
        if (clear || load) begin
            presc_d = '0;
        end else if (state_q == RUNNING) begin
            presc_d = (presc_q == TICK_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    // Prescaler register; holds partial time while stopped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) presc_q <= '0;
        else        presc_q <= presc_d;
    end

`ifdef BCD_SATURATE_EN
    logic all_max, all_zero, at_limit;
    logic hit_q, hit_d;

    // Detect the count sitting at either end of its range.
    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_w[i] != BCD_MAX)  all_max  = 1'b0;
            if (digit_w[i] != BCD_ZERO) all_zero = 1'b0;
        end
    end

    assign at_limit = up_dn ? all_max : all_zero;
    assign inc      = step_ok &  up_dn & ~all_max;
    assign dec      = step_ok & ~up_dn & ~all_zero;
    // Only the first blocked tick at a limit flags wrap; later ones are silent.
    assign wrap_d   = step_ok & at_limit & ~hit_q;

    // Remembers that the limit has already been reported.
    always_comb begin
        hit_d = hit_q;
        if (clear || load) hit_d = 1'b0;
        else if (step_ok)  hit_d = at_limit;
    end

    // Limit-reported flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hit_q <= 1'b0;
        else        hit_q <= hit_d;
    end
`else
    assign inc    = step_ok &  up_dn;
    assign dec    = step_ok & ~up_dn;
    // Carry or borrow out of the top digit means the whole count wrapped.
    assign wrap_d = carry[NUM_DIGITS] | borrow[NUM_DIGITS];
`endif

    // Wrap pulse register, aligned with the new digit values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wrap_q <= 1'b0;
        else        wrap_q <= wrap_d;
    end

    assign wrap = wrap_q;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk_i        (clk),
            .rst_ni       (reset),
            .clear_i      (clear),
            .load_i       (load),
            .load_val_i   (load_val[i*DIGIT_W +: DIGIT_W]),
            .inc_i        (inc),
            .dec_i        (dec),
            .carry_in_i   (carry[i]),
            .borrow_in_i  (borrow[i]),
            .carry_out_o  (carry[i+1]),
            .borrow_out_o (borrow[i+1]),
            .digit_o      (digit_w[i])
        );
    end

    assign count0 = digit_w[0];
    assign count1 = digit_w[1];
    assign count2 = digit_w[2];
    assign count3 = digit_w[3];

endmodule

// File: tb/tb_bcd_count4.sv
// Directed bench for bcd_count4 with TICK_DIV=4. Expectations follow the
// wrap-around build by default and the saturating build when BCD_SATURATE_EN is set.
module tb_bcd_count4;

    localparam int TICK_DIV = 4;

`ifdef BCD_SATURATE_EN
    localparam logic [15:0] UP_LIMIT_CNT = 16'h9999;
    localparam logic [15:0] UP_NEXT_CNT  = 16'h9999;
    localparam logic [15:0] DN_LIMIT_CNT = 16'h0000;
    localparam logic [15:0] DN_NEXT_CNT  = 16'h0000;
`else
    localparam logic [15:0] UP_LIMIT_CNT = 16'h0000;
    localparam logic [15:0] UP_NEXT_CNT  = 16'h0001;
    localparam logic [15:0] DN_LIMIT_CNT = 16'h9999;
    localparam logic [15:0] DN_NEXT_CNT  = 16'h9998;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_stop = 1'b0;
    logic        up_dn = 1'b1;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [3:0]  count0, count1, count2, count3;
    logic        running, wrap;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        clr;
        logic        ld;
        logic [15:0] lv;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [9];

    // Clock.
    always #5 clk = ~clk;

    bcd_count4 #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .up_dn      (up_dn),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .count0     (count0),
        .count1     (count1),
        .count2     (count2),
        .count3     (count3),
        .running    (running),
        .wrap       (wrap)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] exp_cnt,
                         input logic exp_w, input logic exp_r);
        logic [15:0] act;
        act = {count3, count2, count1, count0};
        n_cmp++;
        if (act !== exp_cnt || wrap !== exp_w || running !== exp_r) begin
            n_err++;
            $display("FAIL %s: got count=%h wrap=%b running=%b, expected count=%h wrap=%b running=%b",
                     name, act, wrap, running, exp_cnt, exp_w, exp_r);
        end
    endtask

    // One-cycle clear/load strobe; returns at the negedge after the active edge.
    task automatic op(input logic clr, input logic ld, input logic [15:0] lv);
        clear    = clr;
        load     = ld;
        load_val = lv;
        @(negedge clk);
        clear = 1'b0;
        load  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 16'h0998, 16'h0998};
        vecs[1] = '{1'b0, 1'b1, 16'hA5F3, 16'h0503};
        vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 16'h9999, 16'h9999};
        vecs[4] = '{1'b0, 1'b1, 16'h7C8D, 16'h7080};
        vecs[5] = '{1'b1, 1'b0, 16'h1111, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 16'h1234, 16'h1234};
        vecs[7] = '{1'b1, 1'b1, 16'h5678, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 16'h0000, 16'h0000};

        // Reset state.
        step(3);
        check("reset", 16'h0000, 1'b0, 1'b0);
        reset = 1'b1;
        step(2);
        check("reset_release", 16'h0000, 1'b0, 1'b0);

        // Clear/load table while stopped (no ticks can interfere).
        for (int i = 0; i < 9; i++) begin
            op(vecs[i].clr, vecs[i].ld, vecs[i].lv);
            check($sformatf("table_%0d", i), vecs[i].exp, 1'b0, 1'b0);
        end

        // Start latency and first ticks.
        start_stop = 1'b1;
        step(2);
        check("start_lat2", 16'h0000, 1'b0, 1'b0);
        step(1);
        check("start_lat3", 16'h0000, 1'b0, 1'b1);
        start_stop = 1'b0;
        step(3);
        check("tick1_before", 16'h0000, 1'b0, 1'b1);
        step(1);
        check("tick1", 16'h0001, 1'b0, 1'b1);
        step(3);
        check("tick2_before", 16'h0001, 1'b0, 1'b1);
        step(1);
        check("tick2", 16'h0002, 1'b0, 1'b1);

        // Multi-digit ripple 0999 -> 1000.
        op(1'b0, 1'b1, 16'h0998);
        check("ripple_load", 16'h0998, 1'b0, 1'b1);
        step(3);
        check("ripple_hold", 16'h0998, 1'b0, 1'b1);
        step(1);
        check("ripple_0999", 16'h0999, 1'b0, 1'b1);
        step(3);
        check("ripple_hold2", 16'h0999, 1'b0, 1'b1);
        step(1);
        check("ripple_1000", 16'h1000, 1'b0, 1'b1);

        // Up past 9999.
        op(1'b0, 1'b1, 16'h9999);
        check("up_load", 16'h9999, 1'b0, 1'b1);
        step(3);
        check("up_pre", 16'h9999, 1'b0, 1'b1);
        step(1);
        check("up_limit", UP_LIMIT_CNT, 1'b1, 1'b1);
        step(1);
        check("up_wrap_1cyc", UP_LIMIT_CNT, 1'b0, 1'b1);
        step(3);
        check("up_next", UP_NEXT_CNT, 1'b0, 1'b1);

        // Down past 0000.
        up_dn = 1'b0;
        op(1'b0, 1'b1, 16'h0000);
        check("dn_load", 16'h0000, 1'b0, 1'b1);
        step(3);
        check("dn_pre", 16'h0000, 1'b0, 1'b1);
        step(1);
        check("dn_limit", DN_LIMIT_CNT, 1'b1, 1'b1);
        step(1);
        check("dn_wrap_1cyc", DN_LIMIT_CNT, 1'b0, 1'b1);
        step(3);
        check("dn_next", DN_NEXT_CNT, 1'b0, 1'b1);

        // Pause with prescaler at 2, resume, tick comes 2 clk later.
        up_dn      = 1'b1;
        start_stop = 1'b1;
        op(1'b0, 1'b1, 16'h0042);
        check("pause_load", 16'h0042, 1'b0, 1'b1);
        step(2);
        check("pause_stopped", 16'h0042, 1'b0, 1'b0);
        start_stop = 1'b0;
        step(20);
        check("pause_held", 16'h0042, 1'b0, 1'b0);
        start_stop = 1'b1;
        step(2);
        check("resume_lat2", 16'h0042, 1'b0, 1'b0);
        step(1);
        check("resume_run", 16'h0042, 1'b0, 1'b1);
        start_stop = 1'b0;
        step(1);
        check("resume_plus1", 16'h0042, 1'b0, 1'b1);
        step(1);
        check("resume_tick", 16'h0043, 1'b0, 1'b1);

        // Clear and load together on the tick cycle.
        step(3);
        check("collide_pre", 16'h0043, 1'b0, 1'b1);
        op(1'b1, 1'b1, 16'h1234);
        check("collide", 16'h0000, 1'b0, 1'b1);
        step(3);
        check("collide_presc_clr", 16'h0000, 1'b0, 1'b1);
        step(1);
        check("collide_next_tick", 16'h0001, 1'b0, 1'b1);

        // Asynchronous reset mid-run.
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(8);
        check("post_reset_idle", 16'h0000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
